pwm_peripheral: RTL and testbench

//   Consumes the control registers written by the SPI peripheral and drives 16 output pins.

---
 rtl/pwm_peripheral.sv | 71 +++++++
 tb/tb_pwm_peripheral.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin forced low, forced high, or fed by a shared
// 8-bit PWM whose duty is shadowed at period boundaries to avoid glitches.
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic [15:0]   pwm_out_q, pwm_out_d;
    logic          wrap_q, wrap_d;
    logic          period_start_q, period_start_d;

    logic          tick;
    logic          wrap;
    logic          pwm_sig;
    logic [15:0]   en;
    logic [15:0]   sel;

    always_comb begin
        en      = {en_reg_out_15_8, en_reg_out_7_0};
        sel     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        tick    = (presc_q == PS_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
        wrap    = tick && (cnt_q == 8'hFF);
        duty_d  = wrap ? pwm_duty_cycle : duty_q;
        // 0xFF means 100%, otherwise high for the first duty ticks
        pwm_sig = (duty_q == 8'hFF) || (cnt_q < duty_q);
        pwm_out_d      = en & (~sel | {16{pwm_sig}});
        // delayed one clk so the pulse lines up with the first
        // registered pin value of the new period
        wrap_d         = wrap;
        period_start_d = wrap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            duty_q         <= '0;
            pwm_out_q      <= '0;
            wrap_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            pwm_out_q      <= pwm_out_d;
            wrap_q         <= wrap_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: per-cycle arithmetic reference
// model plus literal waveform measurements (duty, period, reset restart).
module tb_pwm_peripheral;

    localparam int P   = 13;
    localparam int PER = 256 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] en_v = '0;
    logic [15:0] sel_v = '0;
    logic [7:0]  duty = '0;
    logic [15:0] pwm_out;
    logic        period_start;

    int checks = 0;
    int passed = 0;
    bit rand_on = 1'b0;

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_reg_out_7_0 (en_v[7:0]),
        .en_reg_out_15_8(en_v[15:8]),
        .en_reg_pwm_7_0 (sel_v[7:0]),
        .en_reg_pwm_15_8(sel_v[15:8]),
        .pwm_duty_cycle (duty),
        .pwm_out        (pwm_out),
        .period_start   (period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: k = clk edges since reset release.
    int          k = 0;
    int          cnt_pre;
    logic [7:0]  duty_m = '0;
    logic        sig;
    logic [15:0] exp_out = '0;
    logic        exp_ps = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            k = 0;
            duty_m = '0;
            exp_out = '0;
            exp_ps = 1'b0;
        end else begin
            k++;
            cnt_pre = ((k - 1) / P) % 256;
            sig = (duty_m == 8'hFF) || (cnt_pre < int'(duty_m));
            exp_out = en_v & (~sel_v | {16{sig}});
            exp_ps = (k > 1) && (((k - 1) % PER) == 0);
            if ((k % PER) == 0) duty_m = duty;
        end
        #1;
        chk("pwm_out", {16'h0, pwm_out}, {16'h0, exp_out});
        chk("period_start", {31'h0, period_start}, {31'h0, exp_ps});
    end

    task automatic tick_neg();
        @(negedge clk);
        if (rand_on) begin
            en_v[15:1]  = 15'($urandom);
            sel_v[15:1] = 15'($urandom);
        end
    endtask

    task automatic measure(output int hi, output int len,
                           input bit chg, input logic [7:0] nd);
        int b = 0;
        while (!period_start && b < 5000) begin
            tick_neg();
            b++;
        end
        chk("ps_timeout", {31'h0, period_start}, 32'h1);
        hi = 0;
        len = 0;
        do begin
            hi += int'(pwm_out[0]);
            len++;
            if (chg && len == 1000) duty = nd;
            tick_neg();
        end while (!period_start && len < 5000);
    endtask

    initial begin
        int hi, len, n;
        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            en_v  = 16'($urandom);
            sel_v = 16'($urandom);
            duty  = 8'($urandom);
            @(negedge clk);
            chk("rst_out", {16'h0, pwm_out}, 32'h0);
            chk("rst_ps", {31'h0, period_start}, 32'h0);
        end
        en_v = '0;
        rst = 1'b0;
        tick_neg();
        chk("rel_out", {16'h0, pwm_out}, 32'h0);
        chk("rel_ps", {31'h0, period_start}, 32'h0);

        // forced-high enables, then partial enable
        en_v = 16'hFFFF;
        sel_v = '0;
        tick_neg();
        chk("en_all", {16'h0, pwm_out}, 32'hFFFF);
        en_v = 16'h00F0;
        tick_neg();
        chk("en_f0", {16'h0, pwm_out}, 32'h00F0);

        // random traffic across two wraps
        for (int i = 0; i < 2 * PER + 50; i++) begin
            en_v  = 16'($urandom);
            sel_v = 16'($urandom);
            duty  = 8'($urandom);
            tick_neg();
        end

        // 50% duty on pin0
        en_v = 16'h0001;
        sel_v = 16'h0001;
        rand_on = 1'b1;
        duty = 8'h80;
        measure(hi, len, 1'b0, 8'h0);
        measure(hi, len, 1'b0, 8'h0);
        chk("d80_hi", hi, 32'd1664);
        chk("d80_len", len, 32'd3328);

        // 0% and 100%
        duty = 8'h00;
        measure(hi, len, 1'b0, 8'h0);
        for (int i = 0; i < 2; i++) begin
            measure(hi, len, 1'b0, 8'h0);
            chk("d00_hi", hi, 32'd0);
        end
        duty = 8'hFF;
        measure(hi, len, 1'b0, 8'h0);
        for (int i = 0; i < 2; i++) begin
            measure(hi, len, 1'b0, 8'h0);
            chk("dff_hi", hi, 32'd3328);
        end

        // mid-period duty write is deferred to the next period
        duty = 8'h40;
        measure(hi, len, 1'b0, 8'h0);
        measure(hi, len, 1'b1, 8'hC0);
        chk("d40_hi", hi, 32'd832);
        measure(hi, len, 1'b0, 8'h0);
        chk("dc0_hi", hi, 32'd2496);

        // reset mid-period restarts the period with zero duty
        duty = 8'h80;
        measure(hi, len, 1'b0, 8'h0);
        measure(hi, len, 1'b0, 8'h0);
        for (int i = 0; i < 500; i++) tick_neg();
        rst = 1'b1;
        tick_neg();
        chk("midrst_out", {16'h0, pwm_out}, 32'h0);
        chk("midrst_ps", {31'h0, period_start}, 32'h0);
        rst = 1'b0;
        n = 0;
        hi = 0;
        do begin
            tick_neg();
            n++;
            if (!period_start) hi += int'(pwm_out[0]);
        end while (!period_start && n < 5000);
        chk("restart_len", n, PER + 1);
        chk("restart_hi", hi, 32'd0);
        chk("restart_pin", {31'h0, pwm_out[0]}, 32'h1);

        tick_neg();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
